branch_predict_unit: RTL and testbench

Produces the branch-prediction and misprediction-recovery signals that the next-PC selector consumes. The unit predicts conditional branches in IF from a PC-indexed table of 2-bit saturating counters and drives the selector's `branch` input. It tracks the prediction into ID, where it compares it with the resolved outcome. On a misprediction it drives the selector's `miss` and `PC_branch` inputs, trains the table, and counts events.

---
 rtl/bpu_pkg.sv | 15 +
 rtl/branch_predict_unit_sat_counter2.sv | 23 ++
 rtl/branch_predict_unit.sv | 108 ++++++++++
 tb/tb_branch_predict_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: 2-bit counter states,
// the table reset state and the default table depth.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_state_e;

  localparam bht_state_e BHT_RST           = WNT;
  localparam int         DEFAULT_BHT_DEPTH = 16;

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// Next-state function of a 2-bit saturating counter: moves one step toward
// the resolved outcome and saturates at SNT and ST.
module sat_counter2
  import bpu_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next
);

  // Saturating next-state selection
  always_comb begin
    next = state;
    case (state)
      SNT:     next = taken ? WNT : SNT;
      WNT:     next = taken ? WT  : SNT;
      WT:      next = taken ? ST  : WNT;
      ST:      next = taken ? ST  : WT;
      default: next = state;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage branch predictor with ID-stage resolution: PC-indexed table of
// 2-bit counters, misprediction recovery and saturating event counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int BHT_DEPTH = DEFAULT_BHT_DEPTH,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             IF_branch_i,
  input  logic [31:0]      IF_PC_i,
  output logic             pred_taken_o,
  input  logic             ID_taken_i,
  input  logic [31:0]      ID_PC_imm_i,
  input  logic [31:0]      ID_PC_plus_i,
  output logic             miss_o,
  output logic [31:0]      PC_branch_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [BHT_DEPTH-1:0][1:0] bht_r;
  logic [IDX_W-1:0]          if_idx_s;
  logic                      valid_r;
  logic                      pred_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      resolve_s;
  logic [1:0]                bht_next_s;
  logic [CNT_W-1:0]          branch_cnt_r;
  logic [CNT_W-1:0]          miss_cnt_r;
  logic                      unused_s;

  assign if_idx_s     = IF_PC_i[IDX_W+1:2];
  assign unused_s     = ^{IF_PC_i[31:IDX_W+2], IF_PC_i[1:0]};

  // Reads the pre-update table, so same-cycle training is not forwarded.
  assign pred_taken_o = IF_branch_i & bht_r[if_idx_s][1];

  assign resolve_s    = valid_r & ~stall_i;
  assign miss_o       = resolve_s & (pred_r ^ ID_taken_i);
  assign PC_branch_o  = ID_taken_i ? ID_PC_imm_i : ID_PC_plus_i;
  assign branch_cnt_o = branch_cnt_r;
  assign miss_cnt_o   = miss_cnt_r;

  sat_counter2 u_sat (
    .state (bht_r[idx_r]),
    .taken (ID_taken_i),
    .next  (bht_next_s)
  );

  // Table entries are individual flops so each resets asynchronously
  for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bht_r[g] <= BHT_RST;
      end else if (resolve_s && (idx_r == IDX_W'(g))) begin
        bht_r[g] <= bht_next_s;
      end else begin
        bht_r[g] <= bht_r[g];
      end
    end
  end

  // In-flight prediction carried from IF to ID; a miss squashes the IF slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      pred_r  <= 1'b0;
      idx_r   <= '0;
    end else if (stall_i) begin
      valid_r <= valid_r;
      pred_r  <= pred_r;
      idx_r   <= idx_r;
    end else if (miss_o) begin
      valid_r <= 1'b0;
      pred_r  <= pred_r;
      idx_r   <= idx_r;
    end else begin
      valid_r <= IF_branch_i;
      pred_r  <= pred_taken_o;
      idx_r   <= if_idx_s;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_r <= '0;
      miss_cnt_r   <= '0;
    end else begin
      if (resolve_s && (branch_cnt_r != {CNT_W{1'b1}})) begin
        branch_cnt_r <= branch_cnt_r + CNT_W'(1);
      end else begin
        branch_cnt_r <= branch_cnt_r;
      end
      if (miss_o && (miss_cnt_r != {CNT_W{1'b1}})) begin
        miss_cnt_r <= miss_cnt_r + CNT_W'(1);
      end else begin
        miss_cnt_r <= miss_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed steps push expected
// outputs, a monitor pops and compares them once per cycle.
module tb_branch_predict_unit;

  localparam int          CNT_W = 4;
  localparam logic [31:0] IMM   = 32'h0000_1000;
  localparam logic [31:0] PLS   = 32'h0000_0044;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall_i = 1'b0;
  logic             IF_branch_i = 1'b0;
  logic [31:0]      IF_PC_i = 32'h0;
  logic             pred_taken_o;
  logic             ID_taken_i = 1'b0;
  logic [31:0]      ID_PC_imm_i = IMM;
  logic [31:0]      ID_PC_plus_i = PLS;
  logic             miss_o;
  logic [31:0]      PC_branch_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  typedef struct {
    string       nm;
    logic        pred;
    logic        miss;
    logic [31:0] pcb;
    int          bc;
    int          mc;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  branch_predict_unit #(.BHT_DEPTH(16), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .IF_branch_i  (IF_branch_i),
    .IF_PC_i      (IF_PC_i),
    .pred_taken_o (pred_taken_o),
    .ID_taken_i   (ID_taken_i),
    .ID_PC_imm_i  (ID_PC_imm_i),
    .ID_PC_plus_i (ID_PC_plus_i),
    .miss_o       (miss_o),
    .PC_branch_o  (PC_branch_o),
    .branch_cnt_o (branch_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: samples away from edges, on every cycle and right after a reset rise
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.nm, "pred", 32'(pred_taken_o), 32'(e.pred));
        check(e.nm, "miss", 32'(miss_o), 32'(e.miss));
        check(e.nm, "pcb", PC_branch_o, e.pcb);
        check(e.nm, "bcnt", 32'(branch_cnt_o), e.bc);
        check(e.nm, "mcnt", 32'(miss_cnt_o), e.mc);
      end
    end
  end

  task automatic push(input string nm, input logic ep, input logic em,
                      input logic [31:0] epcb, input int ebc, input int emc);
    exp_t e;
    e.nm = nm; e.pred = ep; e.miss = em; e.pcb = epcb; e.bc = ebc; e.mc = emc;
    q.push_back(e);
  endtask

  task automatic step(input string nm, input logic st, input logic ifb, input logic [31:0] pc,
                      input logic tk, input logic ep, input logic em, input logic [31:0] epcb,
                      input int ebc, input int emc);
    stall_i     = st;
    IF_branch_i = ifb;
    IF_PC_i     = pc;
    ID_taken_i  = tk;
    push(nm, ep, em, epcb, ebc, emc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    //    name          st  ifb pc         tk  pred miss pcb  bc mc
    step("reset",       0,  0,  32'h0,     0,  0,   0,   PLS, 0, 0);
    step("br1_if",      0,  1,  32'h40,    0,  0,   0,   PLS, 0, 0);
    step("br1_res",     0,  0,  32'h0,     1,  0,   1,   IMM, 0, 0);
    step("br2_if",      0,  1,  32'h40,    0,  1,   0,   PLS, 1, 1);
    step("br2_res",     0,  0,  32'h0,     1,  0,   0,   IMM, 1, 1);
    step("br3_if",      0,  1,  32'h40,    0,  1,   0,   PLS, 2, 1);
    step("br3_res",     0,  0,  32'h0,     0,  0,   1,   PLS, 2, 1);
    step("br4_if",      0,  1,  32'h40,    0,  1,   0,   PLS, 3, 2);
    step("br4_res",     0,  0,  32'h0,     0,  0,   1,   PLS, 3, 2);
    step("wnt_chk",     0,  1,  32'h40,    0,  0,   0,   PLS, 4, 3);
    for (int i = 0; i < 3; i++)
      step("stall",     1,  0,  32'h0,     1,  0,   0,   IMM, 4, 3);
    step("stall_rel",   0,  0,  32'h0,     1,  0,   1,   IMM, 4, 3);
    step("after_rel",   0,  0,  32'h0,     1,  0,   0,   IMM, 5, 4);
    step("mif_if",      0,  1,  32'h48,    0,  0,   0,   PLS, 5, 4);
    step("mif_res",     0,  1,  32'h40,    1,  1,   1,   IMM, 5, 4);
    step("mif_next",    0,  0,  32'h0,     0,  0,   0,   PLS, 6, 5);
    step("mif_cnt",     0,  0,  32'h0,     0,  0,   0,   PLS, 6, 5);
    step("alias_if",    0,  1,  32'h40,    0,  1,   0,   PLS, 6, 5);
    step("alias_res",   0,  1,  32'h80,    0,  1,   1,   PLS, 6, 5);
    step("alias_after", 0,  1,  32'h80,    0,  0,   0,   PLS, 7, 6);
    step("rmid_stall",  1,  0,  32'h0,     1,  0,   0,   IMM, 7, 6);
    // Release the stall so a miss is pending, then reset between clock edges
    stall_i     = 1'b0;
    IF_branch_i = 1'b0;
    ID_taken_i  = 1'b1;
    push("rmid_pre", 1'b0, 1'b1, IMM, 7, 6);
    @(negedge clk);
    #2;
    push("rmid_rst", 1'b0, 1'b0, IMM, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst",    0,  1,  32'h48,    0,  0,   0,   PLS, 0, 0);
    for (int k = 0; k < 20; k++)
      step("sat",       0,  1,  32'h48,    0,  0,   0,   PLS, (k > 15) ? 15 : k, 0);
    @(negedge clk);
    #3;
    check("drain", "queue", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
